// File: rtl/uart_tx.sv
// AXI4-Stream to UART serialiser: start bit, LSB-first data, optional parity, stop bit(s).
// Bit period is prescale*8 clocks, latched when the word is accepted.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [15:0]           prescale,
    output logic [2:0]            state_dbg
);

    // Handshake: a word transfers on a rising edge where tvalid & tready are both high;
    // tready is high only while idle, and tvalid/tdata are ignored whenever tready is low.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [18:0]             period_q;
    logic [18:0]             cnt_q;
    logic [3:0]              bit_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    par_q;

    logic                    accept;
    logic                    tick;
    logic                    last_data;
    logic                    last_stop;
    logic [15:0]             p_eff;
    logic [18:0]             period_new;

    assign accept     = (state_q == S_IDLE) && input_axis_tvalid;
    assign tick       = (cnt_q == 19'd0);
    assign last_data  = (bit_q == 4'(DATA_WIDTH - 1));
    assign last_stop  = (bit_q == 4'(STOP_BITS - 1));
    assign p_eff      = (prescale == 16'd0) ? 16'd1 : prescale;
    assign period_new = {p_eff, 3'b000} - 19'd1;
    assign state_dbg  = state_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (input_axis_tvalid) state_d = S_START;
            S_START:  if (tick) state_d = S_DATA;
            S_DATA:   if (tick && last_data) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (tick) state_d = S_STOP;
            S_STOP:   if (tick && last_stop) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        txd               = 1'b1;
        input_axis_tready = (state_q == S_IDLE);
        busy              = (state_q != S_IDLE);
        case (state_q)
            S_START:  txd = 1'b0;
            S_DATA:   txd = shift_q[0];
            S_PARITY: txd = (PARITY == 2) ? par_q : ~par_q;
            default:  txd = 1'b1;
        endcase
    end

    // par_q accumulates the XOR of the data bits as they leave the shift register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            period_q <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
        end else if (accept) begin
            period_q <= period_new;
            cnt_q    <= period_new;
            bit_q    <= '0;
            shift_q  <= input_axis_tdata;
            par_q    <= 1'b0;
        end else if (state_q != S_IDLE) begin
            if (tick) begin
                cnt_q <= period_q;
                case (state_q)
                    S_DATA: begin
                        shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
                        par_q   <= par_q ^ shift_q[0];
                        bit_q   <= last_data ? 4'd0 : bit_q + 4'd1;
                    end
                    S_STOP:  bit_q <= bit_q + 4'd1;
                    default: bit_q <= bit_q;
                endcase
            end else begin
                cnt_q <= cnt_q - 19'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no parity, even, odd and two stop bits.
// Every txd level is compared cycle by cycle against a frame built from the sent word.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] tdata;
    logic [15:0] prescale;
    logic [3:0] tv;
    logic [3:0] rdy_v, txd_v, busy_v;
    logic [2:0] st0, st1, st2, st3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u_none (
        .clk(clk), .nrst(nrst), .input_axis_tdata(tdata), .input_axis_tvalid(tv[0]),
        .input_axis_tready(rdy_v[0]), .txd(txd_v[0]), .busy(busy_v[0]),
        .prescale(prescale), .state_dbg(st0));

    uart_tx #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) u_even (
        .clk(clk), .nrst(nrst), .input_axis_tdata(tdata), .input_axis_tvalid(tv[1]),
        .input_axis_tready(rdy_v[1]), .txd(txd_v[1]), .busy(busy_v[1]),
        .prescale(prescale), .state_dbg(st1));

    uart_tx #(.DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .nrst(nrst), .input_axis_tdata(tdata), .input_axis_tvalid(tv[2]),
        .input_axis_tready(rdy_v[2]), .txd(txd_v[2]), .busy(busy_v[2]),
        .prescale(prescale), .state_dbg(st2));

    uart_tx #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .nrst(nrst), .input_axis_tdata(tdata), .input_axis_tvalid(tv[3]),
        .input_axis_tready(rdy_v[3]), .txd(txd_v[3]), .busy(busy_v[3]),
        .prescale(prescale), .state_dbg(st3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers word d to instance w and checks every cycle of the resulting frame.
    task automatic send(input int w, input logic [7:0] d, input int par, input int stops,
                        input logic [15:0] p, input int p_eff, input bit hold, input bit tweak);
        logic lv[$];
        lv = {};
        tdata    = d;
        prescale = p;
        tv[w]    = 1'b1;
        @(posedge clk); #1;
        check($sformatf("w%0d_accept_busy", w), 32'(busy_v[w]), 32'd1);
        check($sformatf("w%0d_accept_tready", w), 32'(rdy_v[w]), 32'd0);
        if (!hold) tv[w] = 1'b0;
        tdata = ~d;
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(d[i]);
        if (par == 2) lv.push_back(^d);
        if (par == 1) lv.push_back(~^d);
        for (int i = 0; i < stops; i++) lv.push_back(1'b1);
        for (int b = 0; b < lv.size(); b++) begin
            for (int c = 0; c < 8 * p_eff; c++) begin
                check($sformatf("w%0d_bit%0d_c%0d_txd", w, b, c), 32'(txd_v[w]), 32'(lv[b]));
                check($sformatf("w%0d_bit%0d_c%0d_busy", w, b, c), 32'(busy_v[w]), 32'd1);
                check($sformatf("w%0d_bit%0d_c%0d_tready", w, b, c), 32'(rdy_v[w]), 32'd0);
                if (tweak && b == 2 && c == 0) prescale = 16'd5;
                @(posedge clk); #1;
            end
        end
        check($sformatf("w%0d_end_tready", w), 32'(rdy_v[w]), 32'd1);
        check($sformatf("w%0d_end_busy", w), 32'(busy_v[w]), 32'd0);
        check($sformatf("w%0d_end_txd", w), 32'(txd_v[w]), 32'd1);
    endtask

    initial begin
        tv       = 4'b0000;
        tdata    = 8'h00;
        prescale = 16'd1;
        nrst     = 1'b0;

        // Reset held with tvalid asserted: nothing may be accepted.
        tv[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", 32'(txd_v), 32'hF);
        check("rst_tready", 32'(rdy_v), 32'hF);
        check("rst_busy", 32'(busy_v), 32'h0);
        check("rst_state0", 32'(st0), 32'd0);
        check("rst_state1", 32'(st1), 32'd0);
        check("rst_state2", 32'(st2), 32'd0);
        check("rst_state3", 32'(st3), 32'd0);
        tv[0] = 1'b0;
        nrst  = 1'b1;
        @(posedge clk); #1;
        check("post_rst_tready", 32'(rdy_v[0]), 32'd1);
        check("post_rst_txd", 32'(txd_v[0]), 32'd1);

        // 0xA5, no parity, prescale 1: 80 clk frame.
        send(0, 8'hA5, 0, 1, 16'd1, 1, 1'b0, 1'b0);

        // Back-to-back with tvalid held across the end of the first frame.
        send(0, 8'h00, 0, 1, 16'd1, 1, 1'b1, 1'b0);
        send(0, 8'hFF, 0, 1, 16'd1, 1, 1'b0, 1'b0);

        // Even then odd parity on 0x07.
        send(1, 8'h07, 2, 1, 16'd1, 1, 1'b0, 1'b0);
        send(2, 8'h07, 1, 1, 16'd1, 1, 1'b0, 1'b0);

        // Two stop bits at prescale 3, live prescale changed mid-frame.
        send(3, 8'h96, 0, 2, 16'd3, 3, 1'b0, 1'b1);

        // Prescale 0 behaves as 1.
        send(0, 8'h3C, 0, 1, 16'd0, 1, 1'b0, 1'b0);

        // Async reset during data bit 4 of 0xC3 (that bit is 0).
        tdata    = 8'hC3;
        prescale = 16'd1;
        tv[0]    = 1'b1;
        @(posedge clk); #1;
        tv[0] = 1'b0;
        repeat (42) @(posedge clk);
        #1;
        check("mid_txd_before", 32'(txd_v[0]), 32'd0);
        check("mid_busy_before", 32'(busy_v[0]), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        check("mid_rst_txd", 32'(txd_v[0]), 32'd1);
        check("mid_rst_tready", 32'(rdy_v[0]), 32'd1);
        check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_idle_txd", 32'(txd_v[0]), 32'd1);
        send(0, 8'h5A, 0, 1, 16'd1, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
